// File: rtl/pool_port_arbiter_pkg.sv
// pool_port_arbiter_pkg: shared state/grant encoding and default widths.
// Revision 1.0
`default_nettype none

package pool_port_arbiter_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;

  // The arbiter state doubles as the 2-bit grant for the port mux.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRODUCE = 2'd1,
    DRAIN   = 2'd2,
    CONSUME = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/pool_port_mux.sv
// pool_port_mux: zero-latency 2:1 pool memory port mux, zero-gated when no requester owns the ports.
// Revision 1.0
`default_nettype none

module pool_port_mux
  import pool_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  arb_state_t            grant,
  input  logic [ADDR_WIDTH-1:0] prod_addr_a,
  input  logic [ADDR_WIDTH-1:0] prod_addr_b,
  input  logic                  prod_rden_a,
  input  logic                  prod_rden_b,
  input  logic                  prod_wren_a,
  input  logic                  prod_wren_b,
  input  logic [ADDR_WIDTH-1:0] cons_addr_a,
  input  logic [ADDR_WIDTH-1:0] cons_addr_b,
  input  logic                  cons_rden_a,
  input  logic                  cons_rden_b,
  output logic [ADDR_WIDTH-1:0] use_addr_a,
  output logic [ADDR_WIDTH-1:0] use_addr_b,
  output logic                  use_rden_a,
  output logic                  use_rden_b,
  output logic                  use_wren_a,
  output logic                  use_wren_b
);

  always_comb begin
    use_addr_a = '0;
    use_addr_b = '0;
    use_rden_a = 1'b0;
    use_rden_b = 1'b0;
    use_wren_a = 1'b0;
    use_wren_b = 1'b0;
    case (grant)
      PRODUCE: begin
        use_addr_a = prod_addr_a;
        use_addr_b = prod_addr_b;
        use_rden_a = prod_rden_a;
        use_rden_b = prod_rden_b;
        use_wren_a = prod_wren_a;
        use_wren_b = prod_wren_b;
      end
      // The consumer is read-only, so write strobes stay low here.
      CONSUME: begin
        use_addr_a = cons_addr_a;
        use_addr_b = cons_addr_b;
        use_rden_a = cons_rden_a;
        use_rden_b = cons_rden_b;
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pool_port_arbiter.sv
// pool_port_arbiter: per-frame producer/drain/consumer sequencing of the shared pool memory ports.
// Revision 1.0
`default_nettype none

module pool_port_arbiter
  import pool_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int DRAIN_CYCLES    = 2,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       continuous,
  input  logic                       prod_done,
  input  logic                       cons_done,
  input  logic [ADDR_WIDTH-1:0]      prod_addr_a,
  input  logic [ADDR_WIDTH-1:0]      prod_addr_b,
  input  logic                       prod_rden_a,
  input  logic                       prod_rden_b,
  input  logic                       prod_wren_a,
  input  logic                       prod_wren_b,
  input  logic [ADDR_WIDTH-1:0]      cons_addr_a,
  input  logic [ADDR_WIDTH-1:0]      cons_addr_b,
  input  logic                       cons_rden_a,
  input  logic                       cons_rden_b,
  output logic [ADDR_WIDTH-1:0]      use_addr_a,
  output logic [ADDR_WIDTH-1:0]      use_addr_b,
  output logic                       use_rden_a,
  output logic                       use_rden_b,
  output logic                       use_wren_a,
  output logic                       use_wren_b,
  output logic                       prod_enable,
  output logic                       cons_enable,
  output logic                       busy,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       err
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  arb_state_t state;
  arb_state_t state_next;
  logic [3:0] drain_cnt;
  logic [3:0] drain_cnt_next;
  logic       frame_done;
  logic       prod_strobe;
  logic       cons_strobe;
  logic       err_event;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    frame_done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = PRODUCE;
      end
      PRODUCE: begin
        if (prod_done) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_cnt == 4'd0) state_next = CONSUME;
        else                   drain_cnt_next = drain_cnt - 4'd1;
      end
      CONSUME: begin
        if (cons_done) begin
          frame_done = 1'b1;
          state_next = continuous ? PRODUCE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Any strobe or done pulse from a requester that does not own the ports is a protocol error.
  assign prod_strobe = prod_rden_a | prod_rden_b | prod_wren_a | prod_wren_b;
  assign cons_strobe = cons_rden_a | cons_rden_b;
  assign err_event   = ((prod_strobe | prod_done) && (state != PRODUCE)) ||
                       ((cons_strobe | cons_done) && (state != CONSUME));

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count <= '0;
      err         <= 1'b0;
    end else begin
      if (frame_done) frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
      if (err_event)  err <= 1'b1;
    end
  end

  assign prod_enable = (state == PRODUCE);
  assign cons_enable = (state == CONSUME);
  assign busy        = (state != IDLE);

  pool_port_mux #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mux (
    .grant       (state),
    .prod_addr_a (prod_addr_a),
    .prod_addr_b (prod_addr_b),
    .prod_rden_a (prod_rden_a),
    .prod_rden_b (prod_rden_b),
    .prod_wren_a (prod_wren_a),
    .prod_wren_b (prod_wren_b),
    .cons_addr_a (cons_addr_a),
    .cons_addr_b (cons_addr_b),
    .cons_rden_a (cons_rden_a),
    .cons_rden_b (cons_rden_b),
    .use_addr_a  (use_addr_a),
    .use_addr_b  (use_addr_b),
    .use_rden_a  (use_rden_a),
    .use_rden_b  (use_rden_b),
    .use_wren_a  (use_wren_a),
    .use_wren_b  (use_wren_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_pool_port_arbiter.sv
// tb_pool_port_arbiter: scoreboard bench for pool_port_arbiter (DRAIN_CYCLES=2 and DRAIN_CYCLES=1 instances).
// Revision 1.0
`default_nettype none

module tb_pool_port_arbiter;

  localparam logic [9:0] PA = 10'h155;
  localparam logic [9:0] PB = 10'h2AA;
  localparam logic [9:0] CA = 10'h0F0;
  localparam logic [9:0] CB = 10'h30F;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       start = 1'b0, continuous = 1'b0, prod_done = 1'b0, cons_done = 1'b0;
  logic [9:0] prod_addr_a = PA, prod_addr_b = PB, cons_addr_a = CA, cons_addr_b = CB;
  logic       prod_rden_a = 1'b0, prod_rden_b = 1'b0, prod_wren_a = 1'b0, prod_wren_b = 1'b0;
  logic       cons_rden_a = 1'b0, cons_rden_b = 1'b0;
  logic [9:0] use_addr_a, use_addr_b;
  logic       use_rden_a, use_rden_b, use_wren_a, use_wren_b;
  logic       prod_enable, cons_enable, busy, err;
  logic [7:0] frame_count;

  logic       d1_start = 1'b0, d1_cont = 1'b0, d1_pdone = 1'b0, d1_cdone = 1'b0;
  logic [9:0] zaddr = '0;
  logic       zbit = 1'b0;
  logic [9:0] d1_addr_a, d1_addr_b;
  logic       d1_rden_a, d1_rden_b, d1_wren_a, d1_wren_b;
  logic       d1_pen, d1_cen, d1_busy, d1_err;
  logic [7:0] d1_fc;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] fc_exp = 8'd0;
  logic [35:0] sb[$];
  string       sbn[$];

  pool_port_arbiter #(.ADDR_WIDTH(10), .DRAIN_CYCLES(2), .FRAME_CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .continuous(continuous),
    .prod_done(prod_done), .cons_done(cons_done),
    .prod_addr_a(prod_addr_a), .prod_addr_b(prod_addr_b),
    .prod_rden_a(prod_rden_a), .prod_rden_b(prod_rden_b),
    .prod_wren_a(prod_wren_a), .prod_wren_b(prod_wren_b),
    .cons_addr_a(cons_addr_a), .cons_addr_b(cons_addr_b),
    .cons_rden_a(cons_rden_a), .cons_rden_b(cons_rden_b),
    .use_addr_a(use_addr_a), .use_addr_b(use_addr_b),
    .use_rden_a(use_rden_a), .use_rden_b(use_rden_b),
    .use_wren_a(use_wren_a), .use_wren_b(use_wren_b),
    .prod_enable(prod_enable), .cons_enable(cons_enable), .busy(busy),
    .frame_count(frame_count), .err(err)
  );

  pool_port_arbiter #(.ADDR_WIDTH(10), .DRAIN_CYCLES(1), .FRAME_CNT_WIDTH(8)) dut1 (
    .clock(clock), .reset(reset), .start(d1_start), .continuous(d1_cont),
    .prod_done(d1_pdone), .cons_done(d1_cdone),
    .prod_addr_a(zaddr), .prod_addr_b(zaddr),
    .prod_rden_a(zbit), .prod_rden_b(zbit), .prod_wren_a(zbit), .prod_wren_b(zbit),
    .cons_addr_a(zaddr), .cons_addr_b(zaddr),
    .cons_rden_a(zbit), .cons_rden_b(zbit),
    .use_addr_a(d1_addr_a), .use_addr_b(d1_addr_b),
    .use_rden_a(d1_rden_a), .use_rden_b(d1_rden_b),
    .use_wren_a(d1_wren_a), .use_wren_b(d1_wren_b),
    .prod_enable(d1_pen), .cons_enable(d1_cen), .busy(d1_busy),
    .frame_count(d1_fc), .err(d1_err)
  );

  // Observation layout: {addr_a, addr_b, rden_a, rden_b, wren_a, wren_b, prod_en, cons_en, busy, frame_count, err}
  function automatic logic [35:0] mk(input logic [9:0] aa, input logic [9:0] ab, input logic [3:0] stb,
                                     input logic pe, input logic ce, input logic bz,
                                     input logic [7:0] fc, input logic e);
    return {aa, ab, stb, pe, ce, bz, fc, e};
  endfunction

  function automatic logic [35:0] obs();
    return {use_addr_a, use_addr_b, use_rden_a, use_rden_b, use_wren_a, use_wren_b,
            prod_enable, cons_enable, busy, frame_count, err};
  endfunction

  function automatic logic [35:0] obs1();
    return {d1_addr_a, d1_addr_b, d1_rden_a, d1_rden_b, d1_wren_a, d1_wren_b,
            d1_pen, d1_cen, d1_busy, d1_fc, d1_err};
  endfunction

  task automatic clear_inputs();
    start = 1'b0; continuous = 1'b0; prod_done = 1'b0; cons_done = 1'b0;
    {prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b} = 4'b0;
    {cons_rden_a, cons_rden_b} = 2'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    fc_exp = 8'd0;
  endtask

  task automatic test_reset();
    logic [35:0] e;
    string n;
    for (int c = 0; c < 3; c++) begin
      reset = (c < 2);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); sbn.push_back("reset_main");
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); sbn.push_back("reset_d1");
      @(negedge clock);
      e = sb.pop_front(); n = sbn.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++; $display("FAIL %s c=%0d: got %h expected %h", n, c, obs(), e);
      end
      e = sb.pop_front(); n = sbn.pop_front(); vectors++;
      if (obs1() !== e) begin
        miscompares++; $display("FAIL %s c=%0d: got %h expected %h", n, c, obs1(), e);
      end
      @(posedge clock); #1;
    end
    fc_exp = 8'd0;
  endtask

  // start at c=0, prod_done at c=15, cons_done at c=35, back in IDLE at c=36.
  task automatic test_basic_frame();
    logic [35:0] e;
    string n;
    logic [3:0] pv;
    logic [1:0] cv;
    for (int c = 0; c <= 36; c++) begin
      pv = (c >= 1 && c <= 15) ? 4'(c) : 4'b0;
      cv = (c >= 18 && c <= 35) ? 2'(c) : 2'b0;
      start = (c == 0); prod_done = (c == 15); cons_done = (c == 35);
      {prod_wren_b, prod_rden_b, prod_wren_a, prod_rden_a} = pv;
      {cons_rden_b, cons_rden_a} = cv;
      if (c == 0)       e = mk(0, 0, 0, 0, 0, 0, fc_exp, 0);
      else if (c <= 15) e = mk(PA, PB, {pv[0], pv[2], pv[1], pv[3]}, 1, 0, 1, fc_exp, 0);
      else if (c <= 17) e = mk(0, 0, 0, 0, 0, 1, fc_exp, 0);
      else if (c <= 35) e = mk(CA, CB, {cv[0], cv[1], 2'b00}, 0, 1, 1, fc_exp, 0);
      else              e = mk(0, 0, 0, 0, 0, 0, fc_exp + 8'd1, 0);
      sb.push_back(e); sbn.push_back("basic_frame");
      @(negedge clock);
      e = sb.pop_front(); n = sbn.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++; $display("FAIL %s c=%0d: got %h expected %h", n, c, obs(), e);
      end
      @(posedge clock); #1;
    end
    fc_exp = fc_exp + 8'd1;
    clear_inputs();
  endtask

  // Four 8-cycle frames: 3 PRODUCE, 2 DRAIN, 3 CONSUME; continuous drops inside the last CONSUME.
  task automatic test_continuous();
    logic [35:0] e;
    string n;
    int r, k;
    for (int c = 0; c <= 33; c++) begin
      r = (c >= 1) ? (c - 1) % 8 : 0;
      k = (c >= 1) ? (c - 1) / 8 : 0;
      start      = (c == 0);
      prod_done  = (c >= 1 && c <= 32 && r == 2);
      cons_done  = (c >= 1 && c <= 32 && r == 7);
      continuous = (c <= 32) && !(k == 3 && r >= 5);
      if (c == 0)      e = mk(0, 0, 0, 0, 0, 0, fc_exp, 0);
      else if (c == 33) e = mk(0, 0, 0, 0, 0, 0, fc_exp + 8'd4, 0);
      else if (r < 3)  e = mk(PA, PB, 0, 1, 0, 1, fc_exp + 8'(k), 0);
      else if (r < 5)  e = mk(0, 0, 0, 0, 0, 1, fc_exp + 8'(k), 0);
      else             e = mk(CA, CB, 0, 0, 1, 1, fc_exp + 8'(k), 0);
      sb.push_back(e); sbn.push_back("continuous");
      @(negedge clock);
      e = sb.pop_front(); n = sbn.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++; $display("FAIL %s c=%0d: got %h expected %h", n, c, obs(), e);
      end
      @(posedge clock); #1;
    end
    fc_exp = fc_exp + 8'd4;
    clear_inputs();
  endtask

  // start ignored in CONSUME; prod_done in IDLE sets err; start wins over prod_done in IDLE.
  task automatic test_ignored();
    logic [35:0] e;
    string n;
    for (int c = 0; c <= 9; c++) begin
      start     = (c == 0 || c == 4 || c == 5 || c == 8);
      prod_done = (c == 1 || c == 7 || c == 8);
      cons_done = (c == 6);
      case (c)
        0:       e = mk(0, 0, 0, 0, 0, 0, fc_exp, 0);
        1:       e = mk(PA, PB, 0, 1, 0, 1, fc_exp, 0);
        2, 3:    e = mk(0, 0, 0, 0, 0, 1, fc_exp, 0);
        4, 5, 6: e = mk(CA, CB, 0, 0, 1, 1, fc_exp, 0);
        7:       e = mk(0, 0, 0, 0, 0, 0, fc_exp + 8'd1, 0);
        8:       e = mk(0, 0, 0, 0, 0, 0, fc_exp + 8'd1, 1);
        default: e = mk(PA, PB, 0, 1, 0, 1, fc_exp + 8'd1, 1);
      endcase
      sb.push_back(e); sbn.push_back("ignored_pulses");
      @(negedge clock);
      e = sb.pop_front(); n = sbn.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++; $display("FAIL %s c=%0d: got %h expected %h", n, c, obs(), e);
      end
      @(posedge clock); #1;
    end
    fc_exp = fc_exp + 8'd1;
    clear_inputs();
  endtask

  // Entered in PRODUCE with err=1: go to DRAIN, then reset there.
  task automatic test_reset_mid_drain();
    logic [35:0] e;
    string n;
    for (int c = 0; c <= 2; c++) begin
      prod_done   = (c == 0);
      reset       = (c == 1);
      prod_rden_a = (c == 1);
      case (c)
        0:       e = mk(PA, PB, 0, 1, 0, 1, fc_exp, 1);
        1:       e = mk(0, 0, 0, 0, 0, 1, fc_exp, 1);
        default: e = mk(0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      sb.push_back(e); sbn.push_back("reset_mid_drain");
      @(negedge clock);
      e = sb.pop_front(); n = sbn.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++; $display("FAIL %s c=%0d: got %h expected %h", n, c, obs(), e);
      end
      @(posedge clock); #1;
    end
    fc_exp = 8'd0;
    clear_inputs();
  endtask

  task automatic test_mask_cons_in_produce();
    logic [35:0] e;
    string n;
    apply_reset();
    for (int c = 0; c <= 2; c++) begin
      start = (c == 0);
      {cons_rden_a, cons_rden_b} = (c == 1) ? 2'b11 : 2'b00;
      prod_rden_a = (c == 2);
      case (c)
        0:       e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        1:       e = mk(PA, PB, 0, 1, 0, 1, 0, 0);
        default: e = mk(PA, PB, 4'b1000, 1, 0, 1, 0, 1);
      endcase
      sb.push_back(e); sbn.push_back("mask_cons_in_produce");
      @(negedge clock);
      e = sb.pop_front(); n = sbn.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++; $display("FAIL %s c=%0d: got %h expected %h", n, c, obs(), e);
      end
      @(posedge clock); #1;
    end
    clear_inputs();
  endtask

  task automatic test_mask_prod_in_consume();
    logic [35:0] e;
    string n;
    apply_reset();
    for (int c = 0; c <= 6; c++) begin
      start       = (c == 0);
      prod_done   = (c == 1);
      prod_wren_a = (c == 4);
      cons_rden_b = (c == 4);
      cons_done   = (c == 5);
      case (c)
        0:       e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        1:       e = mk(PA, PB, 0, 1, 0, 1, 0, 0);
        2, 3:    e = mk(0, 0, 0, 0, 0, 1, 0, 0);
        4:       e = mk(CA, CB, 4'b0100, 0, 1, 1, 0, 0);
        5:       e = mk(CA, CB, 0, 0, 1, 1, 0, 1);
        default: e = mk(0, 0, 0, 0, 0, 0, 8'd1, 1);
      endcase
      sb.push_back(e); sbn.push_back("mask_prod_in_consume");
      @(negedge clock);
      e = sb.pop_front(); n = sbn.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++; $display("FAIL %s c=%0d: got %h expected %h", n, c, obs(), e);
      end
      @(posedge clock); #1;
    end
    fc_exp = 8'd1;
    clear_inputs();
  endtask

  // DRAIN_CYCLES=1: 3-cycle frames (PRODUCE+prod_done, DRAIN, CONSUME+cons_done); 256 frames wrap the count.
  task automatic test_drain1_wrap();
    logic [35:0] e;
    string n;
    int r, k;
    for (int c = 0; c <= 769; c++) begin
      r = (c >= 1) ? (c - 1) % 3 : 0;
      k = (c >= 1) ? (c - 1) / 3 : 0;
      d1_start = (c == 0);
      d1_pdone = (c >= 1 && c <= 768 && r == 0);
      d1_cdone = (c >= 1 && c <= 768 && r == 2);
      d1_cont  = (c <= 768) && (k < 255);
      if (c == 0 || c == 769) e = mk(0, 0, 0, 0, 0, 0, 0, 0);
      else if (r == 0)        e = mk(0, 0, 0, 1, 0, 1, 8'(k), 0);
      else if (r == 1)        e = mk(0, 0, 0, 0, 0, 1, 8'(k), 0);
      else                    e = mk(0, 0, 0, 0, 1, 1, 8'(k), 0);
      sb.push_back(e); sbn.push_back("drain1_wrap");
      @(negedge clock);
      e = sb.pop_front(); n = sbn.pop_front(); vectors++;
      if (obs1() !== e) begin
        miscompares++; $display("FAIL %s c=%0d: got %h expected %h", n, c, obs1(), e);
      end
      @(posedge clock); #1;
    end
    {d1_start, d1_cont, d1_pdone, d1_cdone} = 4'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_basic_frame();
    test_continuous();
    test_ignored();
    test_reset_mid_drain();
    test_basic_frame();
    test_mask_cons_in_produce();
    test_mask_prod_in_consume();
    test_drain1_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
